// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU accumulate sequencer.
// Contents: state_t (IDLE/RUN/FIN), default WIDTH/CNT_W, SAT_VALUE (all ones).
package alu_pkg;
  localparam int WIDTH = 9;
  localparam int CNT_W = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
  localparam logic [WIDTH-1:0] SAT_VALUE = '1;
endpackage

// File: rtl/alu_accum_ctrl_iter_counter.sv
// iter_counter: loadable down-counter for the accumulate iteration count.
// Ports: clk, rst_n (async active-low), load/load_val (load), dec (decrement),
//        value (current count), last (value == 1).
module iter_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (load) value <= load_val;
    else if (dec) value <= value - 1'b1;
  assign last = value == W'(1);
endmodule

// File: rtl/alu_accum_ctrl.sv
// alu_accum_ctrl: multi-cycle sequencer computing count*(operand+cin) on an external adder.
// Ports: clk, rst_n (async active-low); start/operand/count/cin request;
//        busy/done/result/overflow status; add_a/add_b/add_cin drive the adder,
//        add_sum/add_cout return from it.
// Option: ALU_ACCUM_SATURATE_EN forces result to all ones once overflow is seen.
module alu_accum_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = alu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] count,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, op_q, fin_val;
  logic cin_q, accept, last;
  logic [CNT_W-1:0] cnt;

  iter_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(accept), .dec(state == RUN),
    .load_val(count), .value(cnt), .last(last)
  );

  // A new request is taken in FIN as well, giving back-to-back operation.
  assign accept = start && (state == IDLE || state == FIN);
  assign state_nx = accept ? ((count != '0) ? RUN : FIN) :
                    (state == RUN) ? (last ? FIN : RUN) : IDLE;

  // Value the accumulator takes on the final addition; overflow includes this cycle's carry.
`ifdef ALU_ACCUM_SATURATE_EN
  assign fin_val = (overflow | add_cout) ? SAT_VALUE : add_sum;
`else
  assign fin_val = add_sum;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      op_q <= '0;
      cin_q <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= operand;
        cin_q <= cin;
        acc <= '0;
        overflow <= 1'b0;
        if (count == '0) result <= '0;
      end else if (state == RUN) begin
        acc <= add_sum;
        overflow <= overflow | add_cout;
        if (last) result <= fin_val;
      end
    end

  assign busy = state == RUN;
  assign done = state == FIN;
  assign add_a = acc;
  assign add_b = op_q;
  assign add_cin = cin_q;
endmodule

// File: tb/tb_alu_accum_ctrl.sv
// tb_alu_accum_ctrl: directed self-checking bench for alu_accum_ctrl with a behavioural adder.
module tb_alu_accum_ctrl;
  logic clk = 0, rst_n = 0, start = 0, cin = 0;
  logic [8:0] operand = 0;
  logic [6:0] count = 0;
  logic busy, done, overflow, add_cin, add_cout;
  logic [8:0] result, add_a, add_b, add_sum;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 10'(add_cin);

  alu_accum_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operand(operand), .count(count), .cin(cin),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

`ifdef ALU_ACCUM_SATURATE_EN
  localparam logic [31:0] R200X3 = 511, R10X64 = 511;
`else
  localparam logic [31:0] R200X3 = 88, R10X64 = 128;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input int op, input int n, input bit c);
    operand = 9'(op);
    count = 7'(n);
    cin = c;
    start = 1;
  endtask

  // Steps through cycles 1..n+1 after the start edge; optionally re-pulses start at cycle g.
  task automatic track(input int n, input int g, input string tag);
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk); #1;
      start = (k == g);
      if (k == g) begin
        operand = 9'd3;
        count = 7'd5;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(k <= n));
      chk({tag, "_done"}, 32'(done), 32'(k == n + 1));
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_idle_done"}, 32'(done), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_add_a", 32'(add_a), 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle_cycle("pre");

    launch(5, 3, 0);
    track(3, 0, "t5x3");
    chk("t5x3_result", 32'(result), 15);
    chk("t5x3_ovf", 32'(overflow), 0);
    idle_cycle("t5x3");
    chk("t5x3_hold", 32'(result), 15);

    launch(2, 4, 1);
    track(4, 0, "t2x4c");
    chk("t2x4c_result", 32'(result), 12);
    chk("t2x4c_ovf", 32'(overflow), 0);
    idle_cycle("t2x4c");

    launch(200, 3, 0);
    track(3, 0, "t200x3");
    chk("t200x3_result", 32'(result), R200X3);
    chk("t200x3_ovf", 32'(overflow), 1);
    idle_cycle("t200x3");

    launch(77, 0, 0);
    track(0, 0, "tzero");
    chk("tzero_result", 32'(result), 0);
    chk("tzero_ovf", 32'(overflow), 0);
    idle_cycle("tzero");

    launch(10, 64, 0);
    track(64, 10, "t10x64");
    chk("t10x64_result", 32'(result), R10X64);
    chk("t10x64_ovf", 32'(overflow), 1);
    launch(1, 2, 0);
    track(2, 0, "tb2b");
    chk("tb2b_result", 32'(result), 2);
    chk("tb2b_ovf", 32'(overflow), 0);
    idle_cycle("tb2b");

    launch(7, 20, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 0;
    end
    chk("mid_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_add_a", 32'(add_a), 0);
    chk("arst_add_b", 32'(add_b), 0);
    chk("arst_add_cin", 32'(add_cin), 0);
    @(posedge clk); #1;
    rst_n = 1;
    begin
      int seen = 0;
      for (int k = 0; k < 25; k++) begin
        @(posedge clk); #1;
        seen += int'(done) + int'(busy);
      end
      chk("arst_no_done", 32'(seen), 0);
    end
    launch(4, 3, 0);
    track(3, 0, "tpost");
    chk("tpost_result", 32'(result), 12);
    chk("tpost_ovf", 32'(overflow), 0);
    idle_cycle("tpost");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
